puf_eval_ctrl: RTL and testbench

//   Per-challenge measurement sequencer for the dual-mode PUF chain.

---
 rtl/puf_eval_ctrl.sv | 151 +++++++++++++++
 tb/tb_puf_eval_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_eval_ctrl.sv
// Per-challenge measurement sequencer for the dual-mode PUF chain: clears the path counters,
// runs a timed oscillation window, then compares the two counts and returns a response.
module puf_eval_ctrl #(
    parameter int N      = 128,
    parameter int CW     = 16,
    parameter int WIN_W  = 16,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ch_valid,
    output logic             ch_ready,
    input  logic [N-1:0]     challenge,
    input  logic [WIN_W-1:0] window,
    output logic [N-1:0]     sel,
    output logic             puf_en,
    output logic             puf_rst,
    input  logic [CW-1:0]    cnt_a,
    input  logic [CW-1:0]    cnt_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_bit,
    output logic             rsp_tie,
    output logic [CW-1:0]    rsp_diff,
    output logic [2:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // ch_ready is high only in IDLE; rsp_valid is high only in DONE and its payload is held
    // stable until the transfer, after which the controller returns to IDLE.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [WIN_W-1:0] ONE         = WIN_W'(1);
    localparam logic [WIN_W-1:0] CLEAR_LAST  = WIN_W'(1);
    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE - 1);
    localparam logic [WIN_W-1:0] STOP_LAST   = WIN_W'(1);

    state_t           state_q, state_d;
    logic [WIN_W-1:0] tmr_q, tmr_d;
    logic [WIN_W-1:0] win_q;
    logic [N-1:0]     sel_q;
    logic             load;
    logic             capture;
    logic             bit_q, tie_q;
    logic [CW-1:0]    diff_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // tmr_q counts cycles spent in the current state and restarts at 0 on every transition.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + ONE;
        load    = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (ch_valid) begin
                    load    = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (tmr_q == CLEAR_LAST) begin
                    state_d = S_SETTLE;
                    tmr_d   = '0;
                end
            end
            S_SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    state_d = S_RUN;
                    tmr_d   = '0;
                end
            end
            S_RUN: begin
                if (tmr_q == win_q - ONE) begin
                    state_d = S_STOP;
                    tmr_d   = '0;
                end
            end
            S_STOP: begin
                if (tmr_q == STOP_LAST) begin
                    state_d = S_DONE;
                    capture = 1'b1;
                    tmr_d   = '0;
                end
            end
            S_DONE: begin
                tmr_d = '0;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    // sel only changes on accept, so it is constant throughout the excitation window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q <= '0;
            win_q <= '0;
        end else if (load) begin
            sel_q <= challenge;
            win_q <= (window == '0) ? ONE : window;
        end
    end

    // Counters have been idle for two cycles here, so the asynchronous counts are stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_q  <= 1'b0;
            tie_q  <= 1'b0;
            diff_q <= '0;
        end else if (capture) begin
            bit_q  <= (cnt_a > cnt_b);
            tie_q  <= (cnt_a == cnt_b);
            diff_q <= (cnt_a > cnt_b) ? (cnt_a - cnt_b) : (cnt_b - cnt_a);
        end
    end

    assign ch_ready  = (state_q == S_IDLE);
    assign puf_rst   = (state_q == S_IDLE) || (state_q == S_CLEAR);
    assign puf_en    = (state_q == S_RUN);
    assign rsp_valid = (state_q == S_DONE);
    assign sel       = sel_q;
    assign rsp_bit   = bit_q;
    assign rsp_tie   = tie_q;
    assign rsp_diff  = diff_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl: a timeline model of each challenge is compared with
// the DUT on every falling edge, plus directed literal checks of latency, window and response.
module tb_puf_eval_ctrl;

    localparam int N     = 128;
    localparam int CW    = 16;
    localparam int WIN_W = 16;
    localparam int ST    = 4;

    logic             clk;
    logic             reset;
    logic             ch_valid;
    logic             ch_ready;
    logic [N-1:0]     challenge;
    logic [WIN_W-1:0] window;
    logic [N-1:0]     sel;
    logic             puf_en;
    logic             puf_rst;
    logic [CW-1:0]    cnt_a;
    logic [CW-1:0]    cnt_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_bit;
    logic             rsp_tie;
    logic [CW-1:0]    rsp_diff;
    logic [2:0]       dbg_state;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    // counter stimulus: fixed values for directed cases, otherwise new random counts each cycle
    bit           cnt_fixed = 1;
    logic [CW-1:0] fix_a = '0;
    logic [CW-1:0] fix_b = '0;

    // reference model: one challenge in flight, m_t = clock edges since its accept edge
    bit            m_busy = 0;
    int            m_t    = 0;
    int            m_w    = 1;
    logic [N-1:0]  m_sel  = '0;
    logic          m_bit  = 0;
    logic          m_tie  = 0;
    logic [CW-1:0] m_diff = '0;

    puf_eval_ctrl #(.N(N), .CW(CW), .WIN_W(WIN_W), .SETTLE(ST)) dut (
        .clk       (clk),
        .reset     (reset),
        .ch_valid  (ch_valid),
        .ch_ready  (ch_ready),
        .challenge (challenge),
        .window    (window),
        .sel       (sel),
        .puf_en    (puf_en),
        .puf_rst   (puf_rst),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_bit   (rsp_bit),
        .rsp_tie   (rsp_tie),
        .rsp_diff  (rsp_diff),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- counter driver ----------------
    initial forever begin
        @(posedge clk);
        #1;
        if (cnt_fixed) begin
            cnt_a = fix_a;
            cnt_b = fix_b;
        end else begin
            cnt_a = CW'($urandom);
            cnt_b = ($urandom_range(0, 3) == 0) ? cnt_a : CW'($urandom);
        end
    end

    // ---------------- reference model ----------------
    // Timeline after accept: 2 clear, ST settle, W run, 2 stop, then the response is valid.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_busy = 0;
            m_t    = 0;
            m_sel  = '0;
            m_bit  = 0;
            m_tie  = 0;
            m_diff = '0;
        end else if (!m_busy) begin
            if (ch_valid) begin
                m_busy = 1;
                m_t    = 0;
                m_w    = (window == '0) ? 1 : int'(window);
                m_sel  = challenge;
            end
        end else if (m_t >= 4 + ST + m_w) begin
            if (rsp_ready) m_busy = 0;
        end else begin
            m_t++;
            if (m_t == 4 + ST + m_w) begin
                m_bit  = (cnt_a > cnt_b);
                m_tie  = (cnt_a == cnt_b);
                m_diff = (cnt_a >= cnt_b) ? cnt_a - cnt_b : cnt_b - cnt_a;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    initial forever begin
        @(negedge clk);
        if (chk_en && !reset) begin
            chk("ch_ready",  N'(ch_ready),  N'(!m_busy));
            chk("puf_rst",   N'(puf_rst),   N'(!m_busy || m_t < 2));
            chk("puf_en",    N'(puf_en),    N'(m_busy && m_t >= 2 + ST && m_t < 2 + ST + m_w));
            chk("rsp_valid", N'(rsp_valid), N'(m_busy && m_t >= 4 + ST + m_w));
            chk("sel",       sel,           m_sel);
            chk("rsp_bit",   N'(rsp_bit),   N'(m_bit));
            chk("rsp_tie",   N'(rsp_tie),   N'(m_tie));
            chk("rsp_diff",  N'(rsp_diff),  N'(m_diff));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_directed(input logic [N-1:0] chal, input logic [WIN_W-1:0] win,
                                input logic [CW-1:0] a, input logic [CW-1:0] b, input int hold,
                                input int exp_lat, input int exp_en, input logic eb,
                                input logic et, input logic [CW-1:0] ed);
        int k;
        int lat;
        int en_cnt;
        @(posedge clk);
        #1;
        cnt_fixed = 1;
        fix_a     = a;
        fix_b     = b;
        challenge = chal;
        window    = win;
        rsp_ready = 1'b0;
        ch_valid  = 1'b1;
        @(posedge clk);
        #1;
        k         = cyc;
        ch_valid  = 1'b0;
        challenge = {$urandom, $urandom, $urandom, $urandom};
        lat       = -1;
        en_cnt    = 0;
        for (int i = 0; i < 300 && lat < 0; i++) begin
            @(negedge clk);
            if (puf_en) en_cnt++;
            if (rsp_valid) lat = cyc - k;
        end
        chk("lit_latency",  N'(lat),      N'(exp_lat));
        chk("lit_en_width", N'(en_cnt),   N'(exp_en));
        chk("lit_sel",      sel,          chal);
        chk("lit_rsp_bit",  N'(rsp_bit),  N'(eb));
        chk("lit_rsp_tie",  N'(rsp_tie),  N'(et));
        chk("lit_rsp_diff", N'(rsp_diff), N'(ed));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            ch_valid  = i[0];
            challenge = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("hold_valid", N'(rsp_valid), N'(1'b1));
            chk("hold_ready", N'(ch_ready),  N'(1'b0));
            chk("hold_diff",  N'(rsp_diff),  N'(ed));
            chk("hold_sel",   sel,           chal);
        end
        @(posedge clk);
        #1;
        ch_valid  = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("hs_ch_ready",  N'(ch_ready),  N'(1'b1));
        chk("hs_rsp_valid", N'(rsp_valid), N'(1'b0));
    endtask

    task automatic reset_mid_run();
        int seen;
        @(posedge clk);
        #1;
        cnt_fixed = 0;
        challenge = {$urandom, $urandom, $urandom, $urandom};
        window    = 16'd30;
        ch_valid  = 1'b1;
        @(posedge clk);
        #1;
        ch_valid = 1'b0;
        seen     = 0;
        for (int i = 0; i < 50 && seen == 0; i++) begin
            @(negedge clk);
            if (puf_en) seen = 1;
        end
        chk("rst_reached_run", N'(seen), N'(1));
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_puf_en",    N'(puf_en),    N'(1'b0));
        chk("rst_puf_rst",   N'(puf_rst),   N'(1'b1));
        chk("rst_rsp_valid", N'(rsp_valid), N'(1'b0));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rel_ch_ready", N'(ch_ready), N'(1'b1));
        chk("rst_rel_puf_rst",  N'(puf_rst),  N'(1'b1));
        chk("rst_rel_sel",      sel,          N'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        ch_valid  = 1'b0;
        challenge = '0;
        window    = '0;
        rsp_ready = 1'b0;
        cnt_a     = '0;
        cnt_b     = '0;
        reset     = 1'b0;
        #1;
        reset = 1'b1;
        #3;
        chk("reset_ch_ready",  N'(ch_ready),  N'(1'b1));
        chk("reset_puf_en",    N'(puf_en),    N'(1'b0));
        chk("reset_puf_rst",   N'(puf_rst),   N'(1'b1));
        chk("reset_rsp_valid", N'(rsp_valid), N'(1'b0));
        chk("reset_sel",       sel,           N'(0));
        chk("reset_rsp_bit",   N'(rsp_bit),   N'(1'b0));
        chk("reset_rsp_tie",   N'(rsp_tie),   N'(1'b0));
        chk("reset_rsp_diff",  N'(rsp_diff),  N'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        chk_en = 1;

        // window 10, counts 300/250: valid 18 edges after accept
        run_directed({16{8'hA5}}, 16'd10, 16'd300, 16'd250, 0, 18, 10, 1'b1, 1'b0, 16'd50);
        // tie, then the extreme unsigned difference
        run_directed({$urandom, $urandom, $urandom, $urandom}, 16'd5, 16'd777, 16'd777, 0,
                     13, 5, 1'b0, 1'b1, 16'd0);
        run_directed({$urandom, $urandom, $urandom, $urandom}, 16'd3, 16'd0, 16'hFFFF, 0,
                     11, 3, 1'b0, 1'b0, 16'hFFFF);
        // zero window behaves as one cycle
        run_directed({$urandom, $urandom, $urandom, $urandom}, 16'd0, 16'd5, 16'd9, 0,
                     9, 1, 1'b0, 1'b0, 16'd4);
        // consumer stalls 20 cycles while ch_valid pulses
        run_directed({$urandom, $urandom, $urandom, $urandom}, 16'd7, 16'd1000, 16'd1001, 20,
                     15, 7, 1'b0, 1'b0, 16'd1);

        reset_mid_run();

        // back-to-back: ready tied high, a fresh challenge offered every cycle
        cnt_fixed = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            ch_valid  = 1'b1;
            challenge = {$urandom, $urandom, $urandom, $urandom};
            window    = WIN_W'($urandom_range(0, 12));
        end

        // fully random valid/ready traffic
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            ch_valid  = ($urandom_range(0, 2) == 0);
            rsp_ready = ($urandom_range(0, 3) == 0);
            challenge = {$urandom, $urandom, $urandom, $urandom};
            window    = WIN_W'($urandom_range(0, 20));
        end

        @(posedge clk);
        #1;
        ch_valid  = 1'b0;
        rsp_ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("drain_idle", N'(ch_ready), N'(1'b1));
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
